// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, hazard/redirect controls from decode,
// IF/ID pipeline register outputs and fetch performance counters.
interface mips_fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    // Fetch-stage view
    modport master (
        input  stall, branch_taken, branch_target, imem_rdata,
        output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count, bubble_count
    );

    // Pipeline / memory-side view
    modport slave (
        output stall, branch_taken, branch_target, imem_rdata,
        input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count, bubble_count
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register, stall and redirect.
// Optional fetch/bubble counters are built when FETCH_PERF_COUNTERS_EN is defined.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_fetch_stage_if.master       fif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect outranks stall so a taken branch is never lost behind a hazard.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (fif.branch_taken) begin
            pc_d    = fif.branch_target;
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!fif.stall) begin
            pc_d    = pc_plus4;
            instr_d = fif.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign fif.imem_addr     = pc_q;
    assign fif.ifid_instr    = instr_q;
    assign fif.ifid_pc_plus4 = pc4_q;
    assign fif.ifid_valid    = valid_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else if (fif.branch_taken) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end else if (!fif.stall) begin
            fetch_cnt_q  <= fetch_cnt_q + 32'd1;
        end
    end

    assign fif.fetch_count  = fetch_cnt_q;
    assign fif.bubble_count = bubble_cnt_q;
`else
    assign fif.fetch_count  = 32'd0;
    assign fif.bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage: directed test-plan scenarios then random
// stall/redirect traffic, checked against an instruction-level reference model.
module tb_mips_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] bc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
    logic        m_valid;

    mips_fetch_stage_if fif ();

    mips_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    always #5 clk = ~clk;

    // Word at byte address a; aligned addresses give word index + 1.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1 + {a[1:0], 30'd0};
    endfunction

    always_comb fif.imem_rdata = mem_word(fif.imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef FETCH_PERF_COUNTERS_EN
        return c;
`else
        return 32'd0 & c;
`endif
    endfunction

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_instr = NOP_INSTR;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
        m_fc    = 32'd0;
        m_bc    = 32'd0;
    endtask

    // Drive one cycle of stimulus (from a negedge) and queue the post-edge expectation.
    task automatic step(input logic s, input logic b, input logic [31:0] t);
        exp_t e;
        fif.stall         = s;
        fif.branch_taken  = b;
        fif.branch_target = t;
        if (b) begin
            m_instr = NOP_INSTR;
            m_pc4   = 32'd0;
            m_valid = 1'b0;
            m_pc    = t;
            m_bc    = m_bc + 1;
        end else if (!s) begin
            m_instr = mem_word(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fc    = m_fc + 1;
        end
        e.pc    = m_pc;
        e.instr = m_instr;
        e.pc4   = m_pc4;
        e.valid = m_valid;
        e.fc    = cnt_exp(m_fc);
        e.bc    = cnt_exp(m_bc);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_addr"},  fif.imem_addr, RESET_PC);
        chk({tag, "_instr"}, fif.ifid_instr, NOP_INSTR);
        chk({tag, "_pc4"},   fif.ifid_pc_plus4, 32'd0);
        chk({tag, "_valid"}, {31'd0, fif.ifid_valid}, 32'd0);
        chk({tag, "_fcnt"},  fif.fetch_count, 32'd0);
        chk({tag, "_bcnt"},  fif.bubble_count, 32'd0);
    endtask

    // Monitor: the DUT presents a new IF/ID + PC every edge out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr",     fif.imem_addr, e.pc);
                chk("ifid_instr",    fif.ifid_instr, e.instr);
                chk("ifid_pc_plus4", fif.ifid_pc_plus4, e.pc4);
                chk("ifid_valid",    {31'd0, fif.ifid_valid}, {31'd0, e.valid});
                chk("fetch_count",   fif.fetch_count, e.fc);
                chk("bubble_count",  fif.bubble_count, e.bc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        fif.stall         = 1'b0;
        fif.branch_taken  = 1'b0;
        fif.branch_target = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b1;

        // Reset sequence: PC 0,4,8 with words 1,2
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        // Stall 3 edges at PC=8
        repeat (3) step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        // Redirect at PC=12
        step(1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 32'd0);
        // Redirect coinciding with stall
        step(1'b1, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'd0);
        // Wrap-around
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Random traffic, including unaligned targets and stall+redirect overlap
        for (int i = 0; i < 300; i++) begin
            logic s, b;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + ($urandom & 32'hF) : $urandom;
            step(s, b, t);
        end

        // Async reset between edges after a few fetches, with a redirect pending
        repeat (5) step(1'b0, 1'b0, 32'd0);
        fif.branch_taken  = 1'b1;
        fif.branch_target = 32'h0000_0800;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("async_rst");
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        repeat (20) step($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom);

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
